// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory port.
// It takes one request at a time, computes the effective address and checks
// it for legality. A legal request drives the memory strobes for one cycle,
// and a load captures the read data on the following cycle. Every request
// ends with a single-cycle response.
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  fault,
  output logic        mem_write,
  output logic        mem_read,
  output logic [2:0]  xfer_size,
  output logic [31:0] address,
  output logic [31:0] w_data,
  input  logic [31:0] r_data,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a posedge where req_valid && req_ready.
  // req_ready is high only in IDLE. The upstream stage holds req_valid and
  // the request fields stable until that edge. While req_ready is low,
  // req_valid is ignored.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  localparam logic [1:0] FLT_OK      = 2'b00;
  localparam logic [1:0] FLT_MISALGN = 2'b01;
  localparam logic [1:0] FLT_RANGE   = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  state_t      state_q, state_d;
  logic        op_store_q, op_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] result_q, result_d;

  logic [31:0] acc_addr;
  logic [2:0]  acc_size;
  logic        acc_illegal;
  logic        acc_misaligned;
  logic        acc_range;
  logic [1:0]  acc_fault;

  assign acc_addr = base + offset;

  // Decode the incoming request. Illegal encodings take priority over
  // misalignment, and misalignment takes priority over the range check.
  always_comb begin
    acc_size = 3'd4;
    case (funct3[1:0])
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
    acc_illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                     (funct3 == 3'b111) || (op_store && funct3[2]);
    acc_misaligned = ((funct3[1:0] == 2'b01) && acc_addr[0]) ||
                     ((funct3 == 3'b010) && (acc_addr[1:0] != 2'b00));
    acc_range      = (acc_addr >= MEM_LIMIT);
    if (acc_illegal)         acc_fault = FLT_ILLEGAL;
    else if (acc_misaligned) acc_fault = FLT_MISALGN;
    else if (acc_range)      acc_fault = FLT_RANGE;
    else                     acc_fault = FLT_OK;
  end

  // Next-state and request-register updates for the request FSM.
  always_comb begin
    state_d    = state_q;
    op_store_d = op_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    fault_d    = fault_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_store_d = op_store;
          funct3_d   = funct3;
          addr_d     = acc_addr;
          size_d     = acc_size;
          wdata_d    = store_data;
          fault_d    = acc_fault;
          result_d   = 32'd0;
          state_d    = (acc_fault != FLT_OK) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_d = op_store_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        // Memory data arrives sign-extended; unsigned loads clear the upper bits.
        case (funct3_q)
          3'b100:  result_d = {24'd0, r_data[7:0]};
          3'b101:  result_d = {16'd0, r_data[15:0]};
          default: result_d = r_data;
        endcase
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers. Reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'd0;
      size_q     <= 3'd4;
      wdata_q    <= 32'd0;
      fault_q    <= FLT_OK;
      result_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_store_q <= op_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      result_q   <= result_d;
    end
  end

  // Outputs. The strobes are gated by reset so that no write lands during
  // reset. Faulting requests never enter ISSUE, so they never strobe.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_data  = (state_q == RESP) ? result_q : 32'd0;
    fault      = (state_q == RESP) ? fault_q : FLT_OK;
    mem_read   = (state_q == ISSUE) && !op_store_q && !reset;
    mem_write  = (state_q == ISSUE) && op_store_q && !reset;
    address    = addr_q;
    xfer_size  = size_q;
    w_data     = wdata_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. It models the data memory behaviourally,
// including its one-cycle-late, sign-extended read data. A separate
// byte-array reference model derives the expected results, faults and
// latencies.
module tb_load_store_unit;

  localparam int MEM_BYTES = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        op_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  fault;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  xfer_size;
  logic [31:0] address;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  dmem    [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] exp_q [$];

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op_store(op_store), .funct3(funct3), .base(base), .offset(offset),
    .store_data(store_data), .resp_valid(resp_valid), .resp_data(resp_data),
    .fault(fault), .mem_write(mem_write), .mem_read(mem_read),
    .xfer_size(xfer_size), .address(address), .w_data(w_data),
    .r_data(r_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- data memory model ----------------
  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++)
        if (i < int'(xfer_size)) dmem[(int'(address[5:0]) + i) % MEM_BYTES] <= w_data[8*i +: 8];
    end
    if (mem_read) begin
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < 4; i++)
        if (i < int'(xfer_size)) v[8*i +: 8] = dmem[(int'(address[5:0]) + i) % MEM_BYTES];
      if (xfer_size == 3'd1) v = {{24{v[7]}}, v[7:0]};
      if (xfer_size == 3'd2) v = {{16{v[15]}}, v[15:0]};
      r_data <= v;
    end
  end

  // ---------------- reference model ----------------
  // Applies one request to ref_mem by the architectural rules and returns
  // the expected fault code, response data and latency.
  function automatic void ref_access(input logic st, input logic [2:0] f3,
                                     input logic [31:0] b, input logic [31:0] o,
                                     input logic [31:0] sd,
                                     output logic [1:0] flt, output logic [31:0] data,
                                     output int lat);
    logic [31:0] a;
    int          nbytes;
    logic        unsigned_ld;
    a = b + o;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    unsigned_ld = f3[2];
    data = 32'd0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3[2])) flt = 2'b11;
    else if ((a % nbytes) != 0)                                  flt = 2'b01;
    else if (a >= MEM_BYTES)                                     flt = 2'b10;
    else                                                         flt = 2'b00;
    if (flt != 2'b00) begin
      lat = 1;
    end else if (st) begin
      for (int i = 0; i < nbytes; i++) ref_mem[int'(a) + i] = sd[8*i +: 8];
      lat = 2;
    end else begin
      for (int i = 0; i < nbytes; i++) data = data + (32'(ref_mem[int'(a) + i]) << (8*i));
      if (!unsigned_ld && nbytes < 4 && data[8*nbytes-1])
        data = data | (32'hFFFF_FFFF << (8*nbytes));
      lat = 3;
    end
  endfunction

  // ---------------- driver ----------------
  // Presents one request, then observes until the response or a cycle budget.
  // lat = -1 means no response was seen within the budget.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] b,
                        input logic [31:0] o, input logic [31:0] sd,
                        output int lat, output logic [31:0] data, output logic [1:0] flt,
                        output int n_rd, output int n_wr, output logic [31:0] s_addr,
                        output logic [2:0] s_size, output logic [31:0] s_wdata,
                        output int waited);
    lat = -1; data = 'x; flt = 'x; n_rd = 0; n_wr = 0;
    s_addr = 'x; s_size = 'x; s_wdata = 'x; waited = 0;
    @(negedge clk);
    req_valid = 1'b1; op_store = st; funct3 = f3; base = b; offset = o; store_data = sd;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read)  begin n_rd++; s_addr = address; s_size = xfer_size; end
      if (mem_write) begin n_wr++; s_addr = address; s_size = xfer_size; s_wdata = w_data; end
      if (resp_valid) begin
        lat = k; data = resp_data; flt = fault;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; op_store = 1'b0; funct3 = 3'b010;
    base = 32'd0; offset = 32'd0; store_data = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1)     begin n_fail++; $display("FAIL reset req_ready got=%b exp=1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0)    begin n_fail++; $display("FAIL reset resp_valid got=%b exp=0", resp_valid); end
    n_checks++; if (resp_data !== 32'd0)    begin n_fail++; $display("FAIL reset resp_data got=%h exp=0", resp_data); end
    n_checks++; if (fault !== 2'b00)        begin n_fail++; $display("FAIL reset fault got=%b exp=00", fault); end
    n_checks++; if (mem_write !== 1'b0)     begin n_fail++; $display("FAIL reset mem_write got=%b exp=0", mem_write); end
    n_checks++; if (mem_read !== 1'b0)      begin n_fail++; $display("FAIL reset mem_read got=%b exp=0", mem_read); end
    n_checks++; if (address !== 32'd0)      begin n_fail++; $display("FAIL reset address got=%h exp=0", address); end
    n_checks++; if (xfer_size !== 3'd4)     begin n_fail++; $display("FAIL reset xfer_size got=%0d exp=4", xfer_size); end
    n_checks++; if (w_data !== 32'd0)       begin n_fail++; $display("FAIL reset w_data got=%h exp=0", w_data); end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] b;
    logic [31:0] o;
    logic [31:0] sd;
    logic [31:0] exp_data;
    logic [1:0]  exp_flt;
    int          exp_lat;
  } vec_t;

  // Directed loads, stores, faults and address wrap with constant expectations.
  task automatic test_directed();
    vec_t v[$];
    int lat, n_rd, n_wr, waited, m_lat;
    logic [31:0] data, s_addr, s_wdata, m_data;
    logic [1:0]  flt, m_flt;
    logic [2:0]  s_size, exp_size;
    v.push_back('{1'b1, 3'b010, 32'd0, 32'd0, 32'hDF0D873C, 32'd0,        2'b00, 2});
    v.push_back('{1'b0, 3'b010, 32'd0, 32'd0, 32'd0,        32'hDF0D873C, 2'b00, 3});
    v.push_back('{1'b0, 3'b000, 32'd1, 32'd0, 32'd0,        32'hFFFFFF87, 2'b00, 3});
    v.push_back('{1'b0, 3'b100, 32'd1, 32'd0, 32'd0,        32'h00000087, 2'b00, 3});
    v.push_back('{1'b0, 3'b001, 32'd2, 32'd0, 32'd0,        32'hFFFFDF0D, 2'b00, 3});
    v.push_back('{1'b0, 3'b101, 32'd4, 32'hFFFFFFFE, 32'd0, 32'h0000DF0D, 2'b00, 3});
    v.push_back('{1'b1, 3'b001, 32'd2, 32'd0, 32'hAAAA1234, 32'd0,        2'b00, 2});
    v.push_back('{1'b0, 3'b010, 32'd0, 32'd0, 32'd0,        32'h1234873C, 2'b00, 3});
    v.push_back('{1'b1, 3'b000, 32'd3, 32'd0, 32'h00000055, 32'd0,        2'b00, 2});
    v.push_back('{1'b0, 3'b010, 32'd0, 32'd0, 32'd0,        32'h5534873C, 2'b00, 3});
    v.push_back('{1'b0, 3'b010, 32'd2, 32'd0, 32'd0,        32'd0,        2'b01, 1});
    v.push_back('{1'b0, 3'b010, 32'h3C, 32'd4, 32'd0,       32'd0,        2'b10, 1});
    v.push_back('{1'b1, 3'b100, 32'd0, 32'd0, 32'h1,        32'd0,        2'b11, 1});
    v.push_back('{1'b0, 3'b001, 32'd65, 32'd0, 32'd0,       32'd0,        2'b01, 1});
    v.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'd4, 32'd0, 32'h5534873C, 2'b00, 3});
    foreach (v[i]) begin
      ref_access(v[i].st, v[i].f3, v[i].b, v[i].o, v[i].sd, m_flt, m_data, m_lat);
      do_req(v[i].st, v[i].f3, v[i].b, v[i].o, v[i].sd, lat, data, flt, n_rd, n_wr,
             s_addr, s_size, s_wdata, waited);
      exp_size = (v[i].f3[1:0] == 2'b00) ? 3'd1 : (v[i].f3[1:0] == 2'b01) ? 3'd2 : 3'd4;
      n_checks++; if (lat !== v[i].exp_lat) begin n_fail++; $display("FAIL dir[%0d] latency got=%0d exp=%0d", i, lat, v[i].exp_lat); end
      n_checks++; if (data !== v[i].exp_data) begin n_fail++; $display("FAIL dir[%0d] resp_data got=%h exp=%h", i, data, v[i].exp_data); end
      n_checks++; if (flt !== v[i].exp_flt) begin n_fail++; $display("FAIL dir[%0d] fault got=%b exp=%b", i, flt, v[i].exp_flt); end
      n_checks++; if (n_rd !== ((v[i].exp_flt == 2'b00 && !v[i].st) ? 1 : 0)) begin n_fail++; $display("FAIL dir[%0d] mem_read cycles got=%0d", i, n_rd); end
      n_checks++; if (n_wr !== ((v[i].exp_flt == 2'b00 && v[i].st) ? 1 : 0)) begin n_fail++; $display("FAIL dir[%0d] mem_write cycles got=%0d", i, n_wr); end
      if (v[i].exp_flt == 2'b00) begin
        n_checks++; if (s_addr !== v[i].b + v[i].o) begin n_fail++; $display("FAIL dir[%0d] address got=%h exp=%h", i, s_addr, v[i].b + v[i].o); end
        n_checks++; if (s_size !== exp_size) begin n_fail++; $display("FAIL dir[%0d] xfer_size got=%0d exp=%0d", i, s_size, exp_size); end
        if (v[i].st) begin
          n_checks++; if (s_wdata !== v[i].sd) begin n_fail++; $display("FAIL dir[%0d] w_data got=%h exp=%h", i, s_wdata, v[i].sd); end
        end
      end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL dir[%0d] resp_valid pulse width got=%b exp=0", i, resp_valid); end
    end
  endtask

  // Reset in CAPTURE of a load, then in ISSUE of a store.
  task automatic test_reset_mid_op();
    int lat, n_rd, n_wr, waited, m_lat;
    logic [31:0] data, s_addr, s_wdata, m_data;
    logic [1:0]  flt, m_flt;
    logic [2:0]  s_size;
    @(negedge clk);
    req_valid = 1'b1; op_store = 1'b0; funct3 = 3'b010; base = 32'd0; offset = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_capture resp_valid got=%b exp=0", resp_valid); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_capture req_ready got=%b exp=1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_capture late resp_valid got=%b exp=0", resp_valid); end
    ref_access(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, m_flt, m_data, m_lat);
    do_req(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, lat, data, flt, n_rd, n_wr, s_addr, s_size, s_wdata, waited);
    n_checks++; if (data !== m_data || lat !== 3) begin n_fail++; $display("FAIL rst_capture reload got=%h/%0d exp=%h/3", data, lat, m_data); end

    @(negedge clk);
    req_valid = 1'b1; op_store = 1'b1; funct3 = 3'b010; base = 32'd0; offset = 32'd0;
    store_data = 32'h0BAD_F00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_issue mem_write got=%b exp=0", mem_write); end
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_issue resp_valid got=%b exp=0", resp_valid); end
    ref_access(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, m_flt, m_data, m_lat);
    do_req(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, lat, data, flt, n_rd, n_wr, s_addr, s_size, s_wdata, waited);
    n_checks++; if (data !== m_data) begin n_fail++; $display("FAIL rst_issue word0 got=%h exp=%h", data, m_data); end
  endtask

  // Random requests, mostly back to back, checked against the reference model.
  task automatic test_random();
    int lat, n_rd, n_wr, waited, m_lat, gap;
    logic [31:0] data, s_addr, s_wdata, m_data, b, o, sd;
    logic [1:0]  flt, m_flt;
    logic [2:0]  s_size, f3;
    logic        st;
    for (int i = 0; i < 80; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      b  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 72));
      o  = 32'($urandom_range(0, 16)) - 32'd8;
      sd = $urandom;
      ref_access(st, f3, b, o, sd, m_flt, m_data, m_lat);
      exp_q.push_back(m_data);
      gap = $urandom_range(0, 3);
      if (gap == 3) @(negedge clk);
      do_req(st, f3, b, o, sd, lat, data, flt, n_rd, n_wr, s_addr, s_size, s_wdata, waited);
      m_data = exp_q.pop_front();
      n_checks++; if (waited !== 0) begin n_fail++; $display("FAIL rnd[%0d] req_ready wait got=%0d exp=0", i, waited); end
      n_checks++; if (lat !== m_lat) begin n_fail++; $display("FAIL rnd[%0d] latency got=%0d exp=%0d", i, lat, m_lat); end
      n_checks++; if (flt !== m_flt) begin n_fail++; $display("FAIL rnd[%0d] fault got=%b exp=%b (st=%b f3=%b a=%h)", i, flt, m_flt, st, f3, b + o); end
      n_checks++; if (data !== m_data) begin n_fail++; $display("FAIL rnd[%0d] resp_data got=%h exp=%h (st=%b f3=%b a=%h)", i, data, m_data, st, f3, b + o); end
      n_checks++; if (n_rd + n_wr !== ((m_flt == 2'b00) ? 1 : 0)) begin n_fail++; $display("FAIL rnd[%0d] strobe cycles got=%0d", i, n_rd + n_wr); end
    end
  endtask

  initial begin
    req_valid = 1'b0;
    r_data = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      dmem[i] = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
